// File: rtl/alu_multicycle_exec.sv
// Execute-stage ALU: single-cycle logic/arith/branch ops plus an iterative
// 1-bit-per-cycle SLL/SRL shifter behind a start/busy/done handshake.
module alu_multicycle_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               BranchTaken,
  output logic               IllegalOp
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpNor = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;
  localparam logic [3:0] OpSrl = 4'b0101;
  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpLui = 4'b0111;
  localparam logic [3:0] OpBeq = 4'b1000;
  localparam logic [3:0] OpBne = 4'b1001;
  localparam logic [3:0] OpJr  = 4'b1110;

  typedef enum logic {StIdle, StShift} state_e;

  state_e             state_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   sreg_q;
  logic               left_q;
  logic               busy_q, done_q, zero_q, br_q, ill_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]   res_c;
  logic               br_c, ill_c, is_shift;
  logic [WIDTH-1:0]   shift_nxt;

  assign is_shift  = (ALUOperation == OpSrl) || (ALUOperation == OpSll);
  assign shift_nxt = left_q ? (sreg_q << 1) : (sreg_q >> 1);

  always_comb begin
    res_c = '0;
    br_c  = 1'b0;
    ill_c = 1'b0;
    case (ALUOperation)
      OpAnd: res_c = A & B;
      OpOr:  res_c = A | B;
      OpNor: res_c = ~(A | B);
      OpAdd: res_c = A + B;
      OpSub: res_c = A - B;
      OpSrl: res_c = B >> shamt;
      OpSll: res_c = B << shamt;
      OpLui: res_c = B << 16;
      OpBeq: begin
        res_c = A - B;
        br_c  = (A == B);
      end
      OpBne: begin
        res_c = A - B;
        br_c  = (A != B);
      end
      OpJr:  res_c = A;
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sreg_q   <= '0;
      left_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (is_shift && (shamt != '0)) begin
              sreg_q  <= B;
              cnt_q   <= shamt;
              left_q  <= (ALUOperation == OpSll);
              busy_q  <= 1'b1;
              state_q <= StShift;
            end else begin
              result_q <= res_c;
              zero_q   <= (res_c == '0);
              br_q     <= br_c;
              ill_q    <= ill_c;
              done_q   <= 1'b1;
            end
          end
        end
        StShift: begin
          sreg_q <= shift_nxt;
          cnt_q  <= cnt_q - SHAMT_W'(1);
          // Final bit shifts and commits on the same edge.
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= shift_nxt;
            zero_q   <= (shift_nxt == '0);
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ALUResult   = result_q;
  assign Zero        = zero_q;
  assign BranchTaken = br_q;
  assign IllegalOp   = ill_q;

endmodule

// File: doc/alu_multicycle_exec.md
Name: alu_multicycle_exec

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder; consumes its 4-bit ALUOperation code plus register/immediate operands.
- Single-cycle ops (logic, add/sub, LUI, branch compare, JR pass-through) complete in 1 cycle.
- SLL/SRL use an iterative 1-bit-per-cycle shifter under a start/busy/done handshake.
- Produces registered ALUResult, Zero, BranchTaken and IllegalOp for the datapath/PC logic.

Parameters:
WIDTH  32  datapath width in bits
SHAMT_W  5  shift-amount width; max shift = 2^SHAMT_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
ALUOperation  input  4  op code from ALU control
A  input  WIDTH  operand rs
B  input  WIDTH  operand rt / sign-extended immediate
shamt  input  SHAMT_W  shift amount
busy  output  1  high while an op is in flight (SHIFT state)
done  output  1  one-cycle pulse when result valid
ALUResult  output  WIDTH  registered result, held until next completion
Zero  output  1  ALUResult == 0, registered with result
BranchTaken  output  1  branch decision for BEQ/BNE, else 0
IllegalOp  output  1  set when completed op code was unsupported

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset: state=IDLE; busy=0, done=0, ALUResult=0, Zero=1, BranchTaken=0, IllegalOp=0; shift counter and shift register = 0. Reset mid-shift aborts the operation with no done pulse.
- States: IDLE, SHIFT.
- IDLE, start=1, op not a shift or shamt==0:
  - Compute in the same cycle; register all outputs at the next edge with done=1.
  - Latency 1; remain in IDLE.
- IDLE, start=1, op is SLL/SRL with shamt!=0:
  - Latch B into the shift register and shamt into the counter; go to SHIFT, busy=1.
- SHIFT, each cycle:
  - Shift 1 bit (SLL: left, SRL: logical right, zero fill); decrement the counter.
  - When the counter reaches 0: load ALUResult, pulse done, busy=0, return to IDLE.
  - Total latency = shamt+1 cycles from start to done; shamt=31 gives 32 cycles.
- start while busy: ignored; operands not re-latched.
- done is high for exactly 1 cycle. busy and done are never high together.
- Back-to-back: start asserted in the done cycle is accepted, because state is already IDLE.
- Op codes (result computed on A, B):
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 NOR: ~(A|B)
  - 0011 ADD: A+B mod 2^WIDTH, no overflow flag
  - 0100 SUB: A-B mod 2^WIDTH
  - 0101 SRL: B>>shamt
  - 0110 SLL: B<<shamt
  - 0111 LUI: {B[15:0],16'h0000}
  - 1000 BEQ: result A-B; BranchTaken = (A==B)
  - 1001 BNE: result A-B; BranchTaken = (A!=B)
  - 1110 JR: result A (jump target pass-through)
  - 1010–1101, 1111: result 0, IllegalOp=1, Zero=1, latency 1
- BranchTaken=0 and IllegalOp=0 for every legal non-branch op; both update only on completion.
- Zero reflects the registered ALUResult on every completion.

Test Plan:
- Reset then ADD, A=32'h7FFF_FFFF, B=1, start 1 cycle -> next cycle done=1, ALUResult=32'h8000_0000, Zero=0, busy never high.
- SLL, B=32'h0000_0001, shamt=31 -> busy high 31 cycles, done at cycle 32, ALUResult=32'h8000_0000. Repeat with shamt=0 -> done at cycle 1, result=1.
- BEQ with A=B=32'h1234 -> ALUResult=0, Zero=1, BranchTaken=1. BNE with same operands -> BranchTaken=0. BNE with A=5, B=3 -> ALUResult=2, BranchTaken=1.
- SRL, B=32'hF000_0000, shamt=4; pulse start again with other operands while busy -> second start ignored; done at cycle 5 with ALUResult=32'h0F00_0000.
- Op 4'b1111, A=B=32'hFFFF_FFFF -> done at cycle 1, ALUResult=0, IllegalOp=1. Follow with OR, A=32'hF0, B=32'h0F -> ALUResult=32'hFF, IllegalOp=0.
- SLL, shamt=10; assert reset at cycle 4 -> no done pulse, busy=0, ALUResult=0, Zero=1. Next LUI, B=32'h0000_ABCD -> ALUResult=32'hABCD_0000.
